// File: rtl/scan_decode_disp_if.sv
// Pin bundle for the multiplexed seven-segment scanner: enables, nibble data
// with its load strobe, and the registered digit/segment/frame outputs.
interface scan_decode_disp_if #(
  parameter int DIGITS = 8
);
  logic                  G1;
  logic                  G2;
  logic                  G3;
  logic [4*DIGITS-1:0]   D;
  logic                  LOAD;
  logic [DIGITS-1:0]     DIG;
  logic [6:0]            SEG;
  logic                  FRAME;

  modport master (
    output G1, G2, G3, D, LOAD,
    input  DIG, SEG, FRAME
  );

  modport slave (
    input  G1, G2, G3, D, LOAD,
    output DIG, SEG, FRAME
  );
endinterface

// File: rtl/scan_decode_disp.sv
// Multiplexed hex display scanner: IDLE/SHOW/BLANK FSM, frame-coherent shadow
// data and registered active-low digit / active-high segment outputs.
// Optional macro LEADING_ZERO_BLANK_EN blanks zero digits above the highest nonzero one.
module scan_decode_disp #(
  parameter int DIGITS = 8,
  parameter int DIV    = 1000,
  parameter int GUARD  = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  scan_decode_disp_if.slave     bus,
  output logic [1:0]            state_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHOW  = 2'd1,
    BLANK = 2'd2
  } state_t;

  localparam int IW      = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CNT_TOP = (DIV > GUARD) ? DIV : GUARD;
  localparam int CW      = (CNT_TOP > 1) ? $clog2(CNT_TOP) : 1;

  localparam logic [CW-1:0] DIV_LAST   = CW'(DIV - 1);
  localparam logic [CW-1:0] GUARD_LAST = CW'((GUARD > 0) ? GUARD - 1 : 0);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

  state_t                state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d, idx_next;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [4*DIGITS-1:0]   pending_q, pending_d;
  logic [4*DIGITS-1:0]   shadow_q, shadow_d;
  logic [DIGITS-1:0]     dig_q, dig_d;
  logic [6:0]            seg_q, seg_d;
  logic                  frame_q, frame_d;
  logic                  en;
  logic                  wrap;
  logic                  commit;
  logic [3:0]            nib;

  function automatic logic [6:0] seg7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

`ifdef LEADING_ZERO_BLANK_EN
  // True when digit k is not digit 0 and it and every digit above it are zero.
  function automatic logic upper_zero(input logic [4*DIGITS-1:0] v, input logic [IW-1:0] k);
    logic z;
    z = (k != '0);
    for (int i = 1; i < DIGITS; i++) begin
      if (IW'(i) >= k && v[4*i +: 4] != 4'h0) z = 1'b0;
    end
    return z;
  endfunction
`endif

  assign en       = bus.G1 & ~bus.G2 & ~bus.G3;
  assign idx_next = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    wrap    = 1'b0;
    case (state_q)
      IDLE: begin
        if (en) begin
          state_d = SHOW;
          idx_d   = '0;
          cnt_d   = '0;
        end
      end
      SHOW: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d = '0;
          if (GUARD == 0) begin
            idx_d = idx_next;
            wrap  = (idx_q == IDX_LAST);
          end else begin
            state_d = BLANK;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      BLANK: begin
        if (cnt_q == GUARD_LAST) begin
          state_d = SHOW;
          cnt_d   = '0;
          idx_d   = idx_next;
          wrap    = (idx_q == IDX_LAST);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
        cnt_d   = '0;
      end
    endcase
    if (!en) begin
      state_d = IDLE;
      idx_d   = '0;
      cnt_d   = '0;
      wrap    = 1'b0;
    end
  end

  // Shadow only moves at a frame boundary or while idle; a load on that same
  // edge goes straight through so the new frame already shows it.
  always_comb begin
    commit    = wrap | (state_q == IDLE);
    pending_d = bus.LOAD ? bus.D : pending_q;
    shadow_d  = commit ? pending_d : shadow_q;
  end

  always_comb begin
    nib     = 4'h0;
    dig_d   = '1;
    seg_d   = 7'h00;
    frame_d = wrap;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_d == IW'(i)) nib = shadow_d[4*i +: 4];
    end
    if (state_d == SHOW) begin
      for (int i = 0; i < DIGITS; i++) begin
        if (idx_d == IW'(i)) dig_d[i] = 1'b0;
      end
      seg_d = seg7(nib);
`ifdef LEADING_ZERO_BLANK_EN
      if (upper_zero(shadow_d, idx_d)) seg_d = 7'h00;
`endif
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      cnt_q     <= '0;
      pending_q <= '0;
      shadow_q  <= '0;
      dig_q     <= '1;
      seg_q     <= 7'h00;
      frame_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      shadow_q  <= shadow_d;
      dig_q     <= dig_d;
      seg_q     <= seg_d;
      frame_q   <= frame_d;
    end
  end

  assign bus.DIG   = dig_q;
  assign bus.SEG   = seg_q;
  assign bus.FRAME = frame_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_scan_decode_disp.sv
// Directed bench for scan_decode_disp at DIGITS=4, DIV=4, GUARD=1 (20-cycle frame).
module tb_scan_decode_disp;

  logic       CLK = 1'b0;
  logic       RST;
  logic [1:0] state;
  int         chk_cnt  = 0;
  int         pass_cnt = 0;

  localparam logic [11:0] IDLE_OUT = {4'hF, 7'h00, 1'b0};

  scan_decode_disp_if #(.DIGITS(4)) bus ();

  scan_decode_disp #(.DIGITS(4), .DIV(4), .GUARD(1)) dut (
    .CLK     (CLK),
    .RST     (RST),
    .bus     (bus.slave),
    .state_o (state)
  );

  always #5 CLK = ~CLK;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h3F; 4'h1: s = 7'h06; 4'h2: s = 7'h5B; 4'h3: s = 7'h4F;
      4'h4: s = 7'h66; 4'h5: s = 7'h6D; 4'h6: s = 7'h7D; 4'h7: s = 7'h07;
      4'h8: s = 7'h7F; 4'h9: s = 7'h6F; 4'hA: s = 7'h77; 4'hB: s = 7'h7C;
      4'hC: s = 7'h39; 4'hD: s = 7'h5E; 4'hE: s = 7'h79; default: s = 7'h71;
    endcase
    return s;
  endfunction

  // Cycle c counts edges since the IDLE->SHOW edge: 4 SHOW + 1 BLANK per digit.
  function automatic logic [11:0] exp_scan(input int c, input logic [15:0] val);
    int         pos;
    int         dg;
    logic [3:0] dig;
    logic [6:0] seg;
    logic       fr;
    pos = c % 5;
    dg  = (c / 5) % 4;
    dig = 4'hF;
    seg = 7'h00;
    if (pos < 4) begin
      dig[dg] = 1'b0;
      seg     = hex7(val[dg*4 +: 4]);
    end
    fr = (pos == 0 && dg == 0 && c > 0);
    return {dig, seg, fr};
  endfunction

  function automatic logic [11:0] obs();
    return {bus.DIG, bus.SEG, bus.FRAME};
  endfunction

  // Disable for one edge while loading val, then enable; next edge is cycle 0.
  task automatic restart(input logic [15:0] val);
    bus.G1 = 1'b0; bus.LOAD = 1'b1; bus.D = val;
    @(posedge CLK); #1;
    bus.LOAD = 1'b0; bus.G1 = 1'b1;
  endtask

  task automatic test_reset;
    logic [11:0] o;
    RST = 1'b1; bus.G1 = 1'b0; bus.G2 = 1'b0; bus.G3 = 1'b0;
    bus.D = 16'h0; bus.LOAD = 1'b0;
    #3;
    o = obs();
    chk_cnt++;
    if (o !== IDLE_OUT || state !== 2'd0)
      $display("FAIL reset_async got %h st %0d want %h st 0", o, state, IDLE_OUT);
    else pass_cnt++;
    @(posedge CLK); #1;
    RST = 1'b0;
    @(posedge CLK); #1;
    o = obs();
    chk_cnt++;
    if (o !== IDLE_OUT || state !== 2'd0)
      $display("FAIL reset_idle got %h st %0d want %h st 0", o, state, IDLE_OUT);
    else pass_cnt++;
  endtask

  task automatic test_scan;
    logic [11:0] e;
    logic [11:0] o;
    restart(16'h1234);
    for (int c = 0; c <= 44; c++) begin
      @(posedge CLK); #1;
      e = exp_scan(c, 16'h1234);
      o = obs();
      chk_cnt++;
      if (o !== e) $display("FAIL scan c=%0d got %h want %h", c, o, e);
      else pass_cnt++;
    end
  endtask

  task automatic test_load_midframe;
    logic [11:0] e;
    logic [11:0] o;
    restart(16'h1234);
    for (int c = 0; c <= 39; c++) begin
      @(posedge CLK); #1;
      e = exp_scan(c, (c < 20) ? 16'h1234 : 16'hABCD);
      o = obs();
      chk_cnt++;
      if (o !== e) $display("FAIL load_mid c=%0d got %h want %h", c, o, e);
      else pass_cnt++;
      if (c == 7)  begin bus.LOAD = 1'b1; bus.D = 16'h5555; end
      if (c == 8)  bus.D = 16'hABCD;
      if (c == 9)  bus.LOAD = 1'b0;
    end
  endtask

  task automatic test_inhibit;
    logic [11:0] e;
    logic [11:0] o;
    restart(16'hABCD);
    for (int c = 0; c <= 22; c++) begin
      @(posedge CLK); #1;
      if (c < 11)      e = exp_scan(c, 16'hABCD);
      else if (c < 14) e = IDLE_OUT;
      else             e = exp_scan(c - 14, 16'hABCD);
      o = obs();
      chk_cnt++;
      if (o !== e || (c >= 11 && c < 14 && state !== 2'd0))
        $display("FAIL inhibit c=%0d got %h st %0d want %h", c, o, state, e);
      else pass_cnt++;
      if (c == 10) bus.G2 = 1'b1;
      if (c == 12) bus.G3 = 1'b1;
      if (c == 13) begin bus.G2 = 1'b0; bus.G3 = 1'b0; end
    end
  endtask

  task automatic test_async_reset;
    logic [11:0] e;
    logic [11:0] o;
    restart(16'h1234);
    for (int c = 0; c <= 4; c++) begin
      @(posedge CLK); #1;
      e = exp_scan(c, 16'h1234);
      o = obs();
      chk_cnt++;
      if (o !== e) $display("FAIL areset_pre c=%0d got %h want %h", c, o, e);
      else pass_cnt++;
    end
    #2 RST = 1'b1;
    #1;
    o = obs();
    chk_cnt++;
    if (o !== IDLE_OUT || state !== 2'd0)
      $display("FAIL areset_mid got %h st %0d want %h st 0", o, state, IDLE_OUT);
    else pass_cnt++;
    @(posedge CLK); #1;
    RST = 1'b0;
    @(posedge CLK); #1;
    o = obs();
    e = {4'b1110, 7'h3F, 1'b0};
    chk_cnt++;
    if (o !== e) $display("FAIL areset_clr got %h want %h", o, e);
    else pass_cnt++;
    restart(16'h1234);
    for (int c = 0; c <= 24; c++) begin
      @(posedge CLK); #1;
      e = exp_scan(c, 16'h1234);
      o = obs();
      chk_cnt++;
      if (o !== e) $display("FAIL areset_post c=%0d got %h want %h", c, o, e);
      else pass_cnt++;
    end
  endtask

  task automatic test_load_on_wrap;
    logic [11:0] e;
    logic [11:0] o;
    restart(16'h1234);
    for (int c = 0; c <= 29; c++) begin
      @(posedge CLK); #1;
      e = exp_scan(c, (c < 20) ? 16'h1234 : 16'h0F0F);
      o = obs();
      chk_cnt++;
      if (o !== e) $display("FAIL load_wrap c=%0d got %h want %h", c, o, e);
      else pass_cnt++;
      if (c == 19) begin bus.LOAD = 1'b1; bus.D = 16'h0F0F; end
      if (c == 20) bus.LOAD = 1'b0;
    end
  endtask

  task automatic test_leading_zero;
    logic [11:0] e;
    logic [11:0] o;
    logic [15:0] vals [2];
    vals[0] = 16'h0007;
    vals[1] = 16'h0000;
    for (int v = 0; v < 2; v++) begin
      restart(vals[v]);
      for (int c = 0; c <= 19; c++) begin
        @(posedge CLK); #1;
        e = exp_scan(c, vals[v]);
`ifdef LEADING_ZERO_BLANK_EN
        if ((c % 5) < 4 && ((c / 5) % 4) != 0) e[7:1] = 7'h00;
`endif
        o = obs();
        chk_cnt++;
        if (o !== e) $display("FAIL lead_zero v=%h c=%0d got %h want %h", vals[v], c, o, e);
        else pass_cnt++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_load_midframe();
    test_inhibit();
    test_async_reset();
    test_load_on_wrap();
    test_leading_zero();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/scan_decode_disp.md
SCAN_DECODE_DISP -- requirements
Module: scan_decode_disp

Interface
REQ-001 Parameter DIGITS, default 8: number of multiplexed digits, legal range 2..8.
REQ-002 Parameter DIV, default 1000: clock cycles each digit is lit, legal range 2..65535.
REQ-003 Parameter GUARD, default 1: anti-ghost blank cycles between digits, legal range 0..15.
REQ-004 CLK  input  1: single clock; all state changes on rising edge.
REQ-005 RST  input  1: asynchronous, active-high reset.
REQ-006 G1  input  1: enable, active-high.
REQ-007 G2, G3  input  1 each: inhibits, active-high; block is enabled when G1=1 and G2=0 and G3=0.
REQ-008 D  input  4*DIGITS: hex nibbles; nibble k (D[4k+3:4k]) drives digit k; digit DIGITS-1 is most significant.
REQ-009 LOAD  input  1: one-cycle strobe that captures D.
REQ-010 DIG  output  DIGITS: digit selects for common-cathode display, active-low, at most one bit low.
REQ-011 SEG  output  7: segments, active-high; SEG[0]=a through SEG[6]=g.
REQ-012 FRAME  output  1: one-cycle pulse at each scan wrap.

Function
REQ-013 All outputs SHALL be registered; DIG, SEG and FRAME change only on CLK rising edge or reset.
REQ-014 The FSM SHALL have three states: IDLE (DIG all 1, SEG 0), SHOW (DIG[idx]=0, SEG=decode of shadow nibble idx) and BLANK (DIG all 1, SEG 0).
REQ-015 IDLE->SHOW SHALL occur on the first edge with enable true, with idx=0 and the prescaler at 0.
REQ-016 SHOW SHALL last exactly DIV cycles, then go to BLANK, or go directly to the next SHOW when GUARD=0.
REQ-017 BLANK SHALL last exactly GUARD cycles, then enter SHOW with idx+1; idx SHALL wrap from DIGITS-1 to 0.
REQ-018 Scan period SHALL be DIGITS*(DIV+GUARD) cycles.
REQ-019 FRAME SHALL be 1 for the single cycle in which SHOW with idx=0 is entered by wrap; it SHALL NOT pulse on IDLE exit.
REQ-020 Any state with enable false SHALL move to IDLE on the next edge; idx and prescaler SHALL clear; a re-enable restarts at digit 0.
REQ-021 LOAD=1 SHALL copy D into a pending register on that edge.
REQ-022 Pending SHALL copy into shadow only at scan wrap (the FRAME edge) or on any edge while in IDLE, so a frame never shows mixed data.
REQ-023 When LOAD coincides with a wrap or IDLE commit edge, D SHALL bypass to shadow directly, and the new value is displayed in that frame.
REQ-024 Hex decode (gfedcba) SHALL be 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
REQ-025 DIG bits at and above DIGITS SHALL NOT exist; idx SHALL be clog2(DIGITS) bits wide, and the prescaler SHALL be wide enough for DIV-1.

Reset
REQ-026 RST=1 SHALL immediately force IDLE, DIG all 1, SEG 0, FRAME 0, idx 0, prescaler 0, and pending and shadow all 0, independent of CLK.
REQ-027 Deassertion of RST mid-scan SHALL behave as a fresh start per REQ-015.

Configuration
REQ-028 Macro LEADING_ZERO_BLANK_EN defined: in SHOW, any zero nibble above the highest nonzero shadow nibble SHALL output SEG=0 while DIG timing is unchanged; digit 0 always shows its value.
REQ-029 Macro LEADING_ZERO_BLANK_EN undefined: every digit SHALL be decoded per REQ-024, and no blanking logic SHALL be synthesised.

Verification
Bench parameters for all scenarios: DIGITS=4, DIV=4, GUARD=1.
REQ-030 Reset then enable with shadow 0x1234: DIG sequence 1110(4 cycles),1111(1),1101(4),1111,1011(4),1111,0111(4),1111, then wrap; SEG on DIG=1110 is 66, on DIG=0111 is 06; FRAME pulses every 20 cycles.
REQ-031 LOAD D=0xABCD at mid-frame: the current frame still shows old data; from the next FRAME edge, digit 0 shows SEG=5E.
REQ-032 G2 raised during SHOW of digit 2: on the next edge DIG=1111 and SEG=00; on release, digit 0 is shown first and there is no FRAME pulse.
REQ-033 RST asserted between clock edges during BLANK: outputs clear immediately; after release, behaviour is identical to REQ-030.
REQ-034 LOAD on the exact wrap edge with D=0x0F0F: the new frame's digit 0 shows 71 without a one-frame delay.
REQ-035 With LEADING_ZERO_BLANK_EN defined and shadow 0x0007: digits 3..1 show SEG=00 and digit 0 shows 07; with shadow 0x0000, digit 0 shows 3F.
